// File: rtl/ro_response_builder_if.sv
// Signal bundle between the RO response builder, the RO mux/tick synchronisers
// and the error-correction stage.
interface ro_response_builder_if #(
    parameter int N = 264
);
    logic           go;
    logic           ro_a_tick;
    logic           ro_b_tick;
    logic [8:0]     pair_sel;
    logic           ro_en;
    logic [N-1:0]   response;
    logic           start;
    logic           busy;

    modport master (
        output go, ro_a_tick, ro_b_tick,
        input  pair_sel, ro_en, response, start, busy
    );

    modport slave (
        input  go, ro_a_tick, ro_b_tick,
        output pair_sel, ro_en, response, start, busy
    );
endinterface

// File: rtl/ro_response_builder.sv
// Builds an N-bit PUF response by racing RO pairs: one bit per pair, set when
// oscillator A produced more edges than oscillator B within the count window.
module ro_response_builder #(
    parameter int N      = 264,
    parameter int WINDOW = 1024,
    parameter int CNT_W  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    ro_response_builder_if.slave  bus
);
    localparam int PAIR_W = (N > 1) ? $clog2(N) : 1;
    localparam int WIN_W  = $clog2(WINDOW);

    localparam logic [PAIR_W-1:0] PAIR_LAST = PAIR_W'(N - 1);
    localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(WINDOW - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_COUNT,
        S_COMPARE,
        S_DONE
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [PAIR_W-1:0]   r_pair;
    logic [WIN_W-1:0]    r_win;
    logic [CNT_W-1:0]    r_cnt_a;
    logic [CNT_W-1:0]    r_cnt_b;
    logic [N-1:0]        r_work;
    logic [N-1:0]        r_response;
    logic [N-1:0]        w_work_final;
    logic                w_a_wins;
    logic                w_busy;
    logic                w_ro_en;
    logic                w_start;
    logic                w_sel_active;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    // NOTE: every output of this block gets a default first, so no path through
    // the case statement can leave a signal unassigned and infer a latch.
    always_comb begin
        w_state_next = r_state;
        w_busy       = 1'b1;
        w_ro_en      = 1'b0;
        w_start      = 1'b0;
        w_sel_active = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_busy = 1'b0;
                if (bus.go) w_state_next = S_CLEAR;
            end
            S_CLEAR: begin
                w_sel_active = 1'b1;
                w_state_next = S_COUNT;
            end
            S_COUNT: begin
                w_sel_active = 1'b1;
                w_ro_en      = 1'b1;
                if (r_win == WIN_LAST) w_state_next = S_COMPARE;
            end
            S_COMPARE: begin
                w_sel_active = 1'b1;
                w_state_next = (r_pair == PAIR_LAST) ? S_DONE : S_CLEAR;
            end
            S_DONE: begin
                w_start      = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_busy       = 1'b0;
                w_state_next = S_IDLE;
            end
        endcase
    end

    // A tie resolves to 0 so a dead or stuck pair never reads as a 1.
    assign w_a_wins = (r_cnt_a > r_cnt_b);

    // Final word includes the last pair's bit, which is decided in the same cycle.
    always_comb begin
        w_work_final         = r_work;
        w_work_final[r_pair] = w_a_wins;
    end

    // NOTE: the work and response words are plain flops here, so they are
    // cleared by reset like any other state; an aborted build leaves no residue.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pair     <= '0;
            r_win      <= '0;
            r_cnt_a    <= '0;
            r_cnt_b    <= '0;
            r_work     <= '0;
            r_response <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.go) begin
                        r_pair <= '0;
                        r_work <= '0;
                    end
                end
                S_CLEAR: begin
                    r_cnt_a <= '0;
                    r_cnt_b <= '0;
                    r_win   <= '0;
                end
                S_COUNT: begin
                    r_win <= r_win + 1'b1;
                    if (bus.ro_a_tick && (r_cnt_a != CNT_MAX)) r_cnt_a <= r_cnt_a + 1'b1;
                    if (bus.ro_b_tick && (r_cnt_b != CNT_MAX)) r_cnt_b <= r_cnt_b + 1'b1;
                end
                S_COMPARE: begin
                    r_work[r_pair] <= w_a_wins;
                    if (r_pair == PAIR_LAST) r_response <= w_work_final;
                    else                     r_pair     <= r_pair + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy     = w_busy;
    assign bus.ro_en    = w_ro_en;
    assign bus.start    = w_start;
    assign bus.pair_sel = w_sel_active ? 9'(r_pair) : 9'd0;
    assign bus.response = r_response;

endmodule

// File: doc/ro_response_builder.md
RO_RESPONSE_BUILDER -- requirements
Module: ro_response_builder

Interface
REQ-001 Parameter N, default 264, is the number of RO pairs and the response width; it matches the error-correction stage.
REQ-002 Parameter WINDOW, default 1024, is the count window in clk cycles per pair (WINDOW >= 2).
REQ-003 Parameter CNT_W, default 16, is the per-RO edge counter width.
REQ-004 One clock and one synchronous active-high reset, as listed below.
REQ-005 clk  in  1  single system clock; all logic on the rising edge.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 go  in  1  single-cycle request to build a new response.
REQ-008 ro_a_tick  in  1  one-cycle pulse per edge of the selected pair's RO A, already synchronised to clk.
REQ-009 ro_b_tick  in  1  one-cycle pulse per edge of the selected pair's RO B, already synchronised to clk.
REQ-010 pair_sel  out  9  index of the RO pair currently routed to the tick inputs.
REQ-011 ro_en  out  1  enables the oscillators; high only while counting.
REQ-012 response  out  N  last completed response word.
REQ-013 start  out  1  one-cycle pulse marking response valid; drives the error-correction start input.
REQ-014 busy  out  1  high from the accepted go until the start pulse, inclusive.

Function
REQ-015 The state machine SHALL have states IDLE, CLEAR, COUNT, COMPARE and DONE.
REQ-016 In IDLE with go=1: pair index := 0, clear the work register, go to CLEAR; go is ignored in every other state.
REQ-017 CLEAR lasts 1 cycle: cnt_a := 0, cnt_b := 0, window counter := 0, then go to COUNT.
REQ-018 COUNT lasts exactly WINDOW cycles with ro_en=1; each cycle cnt_a += ro_a_tick and cnt_b += ro_b_tick.
REQ-019 Both counters SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-020 Ticks arriving outside COUNT SHALL be ignored; simultaneous A and B ticks both count.
REQ-021 COMPARE lasts 1 cycle: work[pair] := 1 if cnt_a > cnt_b, else 0 (a tie gives 0).
REQ-022 From COMPARE: if pair = N-1 go to DONE, else pair += 1 and go to CLEAR.
REQ-023 On entry to DONE, response := work; in the DONE cycle start=1; then go to IDLE.
REQ-024 response SHALL change only on entry to DONE and is held at all other times.
REQ-025 pair_sel SHALL equal the current pair index in CLEAR, COUNT and COMPARE, and 0 otherwise.
REQ-026 Each pair takes WINDOW+2 cycles; start SHALL occur N*(WINDOW+2)+1 cycles after the go cycle.
REQ-027 ro_en SHALL be 0 in every state other than COUNT.
REQ-028 busy SHALL be 1 in CLEAR, COUNT, COMPARE and DONE, and 0 in IDLE.

Reset
REQ-029 While rst=1 the block SHALL enter IDLE and hold start=0, busy=0, ro_en=0, pair_sel=0, response=0, and clear all counters and the work register.
REQ-030 rst asserted mid-build SHALL abort the build: no start pulse is issued and response stays 0.
REQ-031 rst SHALL take priority over go in the same cycle.

Verification
REQ-032 N=8, WINDOW=16; pair p gets 3 A-ticks and 1 B-tick for even p, and the reverse for odd p -> start after 8*18+1=145 cycles; response=8'b01010101; start high for exactly 1 cycle.
REQ-033 Equal tick counts (5 and 5) for every pair -> response=0; a second go repeats the same timing.
REQ-034 CNT_W=2, 10 A-ticks and 3 B-ticks -> both counters saturate at 3, the tie gives bit 0, and no wrap occurs.
REQ-035 go pulsed repeatedly while busy, and ticks applied during IDLE, CLEAR and COMPARE -> single build, timing unchanged, stray ticks not counted.
REQ-036 rst during pair 4 of a build -> no start pulse, all outputs 0; a fresh go then completes normally.
REQ-037 Checker: ro_en high exactly WINDOW cycles per pair; pair_sel steps 0..N-1 in order; response stable outside the start cycle.
